// File: rtl/watch_dog_timer_if.sv
// Watchdog service interface: enable/kick from the supervisor and the reset request back to it.
`default_nettype none

interface watch_dog_timer_if;
  logic wd_en;
  logic rst_o;

  modport master (output wd_en, input rst_o);
  modport slave  (input wd_en, output rst_o);
endinterface

`default_nettype wire

// File: rtl/watch_dog_timer.sv
// Watchdog timer: raises a level reset request after TIMEOUT consecutive enabled cycles;
// dropping wd_en for one cycle kicks the count back to zero and releases the request.
`default_nettype none

module watch_dog_timer #(
  parameter int TIMEOUT = 100,
  parameter int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  watch_dog_timer_if.slave   wd
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rst_o_q, rst_o_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rst_o_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rst_o_q <= rst_o_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rst_o_nxt = rst_o_q;
    case (state)
      IDLE: begin
        rst_o_nxt = 1'b0;
        if (wd.wd_en) begin
          // A one-cycle timeout expires on the very first enabled edge.
          if (TIMEOUT == 1) begin
            state_nxt = EXPIRED;
            rst_o_nxt = 1'b1;
          end else begin
            state_nxt = COUNT;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      COUNT: begin
        if (!wd.wd_en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rst_o_nxt = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = EXPIRED;
          rst_o_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      EXPIRED: begin
        if (!wd.wd_en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rst_o_nxt = 1'b0;
        end else begin
          rst_o_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        rst_o_nxt = 1'b0;
      end
    endcase
  end

  assign wd.rst_o = rst_o_q;

endmodule

`default_nettype wire

// File: tb/tb_watch_dog_timer.sv
// Bench for watch_dog_timer: directed scenarios plus random traffic, checked against a run-length model.
`default_nettype none

module tb_watch_dog_timer;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   run_len;

  watch_dog_timer_if if_hi ();
  watch_dog_timer_if if_lo ();

  watch_dog_timer #(.TIMEOUT(100)) dut_hi (.clk(clk), .rst(rst), .wd(if_hi.slave));
  watch_dog_timer #(.TIMEOUT(1))   dut_lo (.clk(clk), .rst(rst), .wd(if_lo.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  // Expiry depends only on how many consecutive enabled edges have been seen since the last
  // reset or kick; the request is high exactly when that run has reached TIMEOUT.
  task automatic step(input logic en, input logic r);
    @(negedge clk);
    if_hi.wd_en = en;
    if_lo.wd_en = en;
    rst         = r;
    @(posedge clk);
    if (!r || !en) run_len = 0;
    else run_len = run_len + 1;
    #1;
    check("rst_o_t100", if_hi.rst_o, (run_len >= 100) ? 1'b1 : 1'b0);
    check("rst_o_t1",   if_lo.rst_o, (run_len >= 1)   ? 1'b1 : 1'b0);
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    run_len     = 0;
    rst         = 1'b0;
    if_hi.wd_en = 1'b1;
    if_lo.wd_en = 1'b1;

    // Reset held with enable high
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("reset_hi", if_hi.rst_o, 1'b0);
    check("reset_lo", if_lo.rst_o, 1'b0);

    // Basic expiry
    step(1'b0, 1'b1);
    run_en(99);
    check("pre_expiry", if_hi.rst_o, 1'b0);
    step(1'b1, 1'b1);
    check("expiry_edge", if_hi.rst_o, 1'b1);
    run_en(6);
    check("expired_hold", if_hi.rst_o, 1'b1);

    // Release and restart
    step(1'b0, 1'b1);
    check("release", if_hi.rst_o, 1'b0);
    check("release_lo", if_lo.rst_o, 1'b0);
    step(1'b0, 1'b1);
    run_en(1);
    check("t1_first_edge", if_lo.rst_o, 1'b1);
    run_en(98);
    check("restart_pre", if_hi.rst_o, 1'b0);
    run_en(1);
    check("restart_expiry", if_hi.rst_o, 1'b1);
    step(1'b0, 1'b1);

    // Periodic kick every 99 enabled cycles
    for (int k = 0; k < 10; k++) begin
      run_en(99);
      step(1'b0, 1'b1);
    end
    check("periodic_kick", if_hi.rst_o, 1'b0);

    // Kick on the edge that would have expired
    run_en(99);
    step(1'b0, 1'b1);
    check("boundary_kick", if_hi.rst_o, 1'b0);
    run_en(99);
    check("boundary_pre", if_hi.rst_o, 1'b0);
    run_en(1);
    check("boundary_expiry", if_hi.rst_o, 1'b1);

    // Mid-count reset
    step(1'b0, 1'b1);
    run_en(50);
    step(1'b1, 1'b0);
    check("midreset_lo", if_lo.rst_o, 1'b0);
    run_en(99);
    check("midreset_pre", if_hi.rst_o, 1'b0);
    run_en(1);
    check("midreset_expiry", if_hi.rst_o, 1'b1);

    // Reset while expired
    step(1'b1, 1'b0);
    check("expired_reset", if_hi.rst_o, 1'b0);

    // Random traffic: mostly enabled so long runs occur, with occasional kicks and resets
    for (int i = 0; i < 3000; i++) begin
      logic en_r;
      logic rst_r;
      en_r  = ($urandom_range(0, 199) != 0);
      rst_r = ($urandom_range(0, 499) != 0);
      step(en_r, rst_r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
